// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 4:1 mux channel-scan sequencer.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } scan_state_e;

  // Lowest enabled channel at or above 'from'. The returned MSB is a found flag.
  // 'from' is one bit wider than a select, so from == NUM_CH means "none left".
  function automatic logic [SEL_W:0] next_en_ch(input logic [NUM_CH-1:0] mask,
                                                input logic [SEL_W:0]    from);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i[SEL_W:0] >= from)) r = {1'b1, i[SEL_W-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell timer: counts cycles while enabled and pulses o_tick on the last
// cycle of each dwell window, restarting from zero on that same edge.
module mux_scan_dwell_cnt #(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CNT_W'(DWELL - 1));

  // Count up inside a dwell window; wrap on the terminal count or when cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_cnt <= '0;
    else if (i_clear || o_tick)  r_cnt <= '0;
    else if (i_en)               r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/mux_scan_seq.sv
// Channel-scan sequencer for the 4:1 single-bit mux. Steps the select over
// channels 0..3 with a fixed dwell, captures the mux return per channel and
// publishes the 4-bit word with a one-cycle done pulse.
// Optional build macro MUX_SCAN_MASK_EN adds i_ch_mask: disabled channels are
// skipped with zero dwell and read back as 0.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_cont,
  input  logic              i_mux_out,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NUM_CH-1:0] i_ch_mask,
`endif
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_busy,
  output logic              o_done,
  output logic [NUM_CH-1:0] o_sample
);

  scan_state_e       r_state;
  logic [NUM_CH-1:0] r_shadow;
  logic              w_tick;
  logic              w_settle;
  logic              w_arm;
  logic              w_first_vld;
  logic [SEL_W-1:0]  w_first;
  logic              w_next_vld;
  logic [SEL_W-1:0]  w_next;
  logic [NUM_CH-1:0] w_word;

  assign w_settle = (r_state == SETTLE);
  // A scan arms from IDLE on start, or re-arms from DONE in continuous mode
  // (cont wins over start there, since start is never looked at outside IDLE).
  assign w_arm = ((r_state == IDLE) && i_start) || ((r_state == DONE) && i_cont);

  mux_scan_dwell_cnt #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (!w_settle),
    .i_en    (w_settle),
    .o_tick  (w_tick)
  );

`ifdef MUX_SCAN_MASK_EN
  logic [NUM_CH-1:0] r_mask;

  // First channel comes from the live mask (it is latched on the arm edge);
  // subsequent channels come from the latched copy.
  always_comb begin
    {w_first_vld, w_first} = next_en_ch(i_ch_mask, '0);
    {w_next_vld,  w_next}  = next_en_ch(r_mask, {1'b0, o_sel} + 3'd1);
  end

  // Latch the channel mask whenever a scan is armed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_mask <= '0;
    else if (w_arm) r_mask <= i_ch_mask;
  end
`else
  // Without the mask every channel is scanned in order.
  always_comb begin
    w_first_vld = 1'b1;
    w_first     = '0;
    w_next_vld  = (o_sel != SEL_W'(NUM_CH - 1));
    w_next      = o_sel + SEL_W'(1);
  end
`endif

  // Captured word including the bit arriving this cycle, so the final channel
  // goes straight from the mux into o_sample without an extra cycle.
  always_comb begin
    w_word        = r_shadow;
    w_word[o_sel] = i_mux_out;
  end

  // Scan FSM with registered sel/busy/done/sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      o_sel    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_sample <= '0;
    end else if (w_arm) begin
      r_shadow <= '0;
      o_busy   <= 1'b1;
      if (w_first_vld) begin
        r_state <= SETTLE;
        o_sel   <= w_first;
        o_done  <= 1'b0;
      end else begin
        // Empty mask: nothing to dwell on, report an all-zero word at once.
        r_state  <= DONE;
        o_sel    <= '0;
        o_done   <= 1'b1;
        o_sample <= '0;
      end
    end else begin
      case (r_state)
        SETTLE: begin
          if (w_tick) begin
            r_shadow <= w_word;
            if (w_next_vld) begin
              o_sel <= w_next;
            end else begin
              r_state  <= DONE;
              o_done   <= 1'b1;
              o_sample <= w_word;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          o_sel   <= '0;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          o_sel   <= '0;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: a DWELL=2 instance driven with directed and random
// scans, plus a DWELL=1 instance. Expected select sequence, done timing and
// sample word are derived from the list of enabled channels and the dwell.
module tb_mux_scan_seq;
  localparam int D  = 2;
  localparam int D1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] ins = '0;
  logic [3:0] ins1 = '0;
  logic [3:0] mask = 4'hF;
  logic       mux_out, mux_out1;
  logic [1:0] sel, sel1;
  logic       busy, done, busy1, done1;
  logic [3:0] sample, sample1;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Model 4:1 mux on the return path.
  assign mux_out  = ins[sel];
  assign mux_out1 = ins1[sel1];

  mux_scan_seq #(.DWELL(D), .CNT_W(8)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_cont    (cont),
    .i_mux_out (mux_out),
`ifdef MUX_SCAN_MASK_EN
    .i_ch_mask (mask),
`endif
    .o_sel     (sel),
    .o_busy    (busy),
    .o_done    (done),
    .o_sample  (sample)
  );

  mux_scan_seq #(.DWELL(D1), .CNT_W(4)) dut1 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start1),
    .i_cont    (1'b0),
    .i_mux_out (mux_out1),
`ifdef MUX_SCAN_MASK_EN
    .i_ch_mask (4'hF),
`endif
    .o_sel     (sel1),
    .o_busy    (busy1),
    .o_done    (done1),
    .o_sample  (sample1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called in the cycle right after the arming edge; returns in the done cycle.
  // poke_j >= 0 raises start during that cycle of the scan (must be ignored).
  task automatic observe_scan(input string tag, input logic [3:0] pat,
                              input logic [3:0] msk, input int poke_j);
    int en[$];
    int k;
    for (int c = 0; c < 4; c++) if (msk[c]) en.push_back(c);
    k = en.size();
    for (int j = 0; j <= k * D; j++) begin
      if (j < k * D) begin
        chk({tag, "_sel"}, 32'(sel), 32'(en[j / D]));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_done0"}, 32'(done), 32'd0);
        start = (j == poke_j);
        @(posedge clk); #1;
      end else begin
        start = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busyd"}, 32'(busy), 32'd1);
        chk({tag, "_sample"}, 32'(sample), 32'(pat & msk));
      end
    end
  endtask

  task automatic check_idle(input string tag, input logic [3:0] held);
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_sel"}, 32'(sel), 32'd0);
    chk({tag, "_idle_sample"}, 32'(sample), 32'(held));
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] msk;
    int         prev_done;
    int         k;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_sample1", 32'(sample1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single scan, i_0..i_3 = 1,0,1,1.
    ins = 4'b1101;
    mask = 4'hF;
    do_start();
    observe_scan("scan1", 4'b1101, 4'hF, -1);
    check_idle("scan1", 4'b1101);

    // Start pulsed mid-scan is ignored: exactly one done, sample held after.
    ins = 4'b0110;
    do_start();
    observe_scan("busystart", 4'b0110, 4'hF, 3);
    for (int i = 0; i < 4; i++) check_idle("busystart", 4'b0110);

    // Continuous mode for three scans with new inputs between scans.
    cont = 1'b1;
    ins = 4'($urandom);
    prev_done = -1;
    do_start();
    for (int s = 0; s < 3; s++) begin
      pat = ins;
      observe_scan("cont", pat, 4'hF, -1);
      if (prev_done >= 0) chk("cont_period", 32'(cyc - prev_done), 32'(4 * D + 1));
      prev_done = cyc;
      if (s < 2) begin
        ins = 4'($urandom);
        @(posedge clk); #1;
      end else begin
        cont = 1'b0;
        check_idle("cont_end", pat);
      end
    end

    // Guarantee a non-zero sample so the reset clears something visible.
    ins = 4'b1011;
    do_start();
    observe_scan("prerst", 4'b1011, 4'hF, -1);
    check_idle("prerst", 4'b1011);

    // Reset in the middle of a scan.
    ins = 4'($urandom);
    do_start();
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sample", 32'(sample), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("inrst_done", 32'(done), 32'd0);
      chk("inrst_busy", 32'(busy), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    ins = 4'($urandom);
    pat = ins;
    do_start();
    observe_scan("postrst", pat, 4'hF, -1);
    check_idle("postrst", pat);

    // DWELL=1 instance, inputs 0,1,1,0.
    for (int t = 0; t < 2; t++) begin
      ins1 = (t == 0) ? 4'b0110 : 4'($urandom);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int j = 0; j < 4 * D1; j++) begin
        chk("d1_sel", 32'(sel1), 32'(j / D1));
        chk("d1_done0", 32'(done1), 32'd0);
        @(posedge clk); #1;
      end
      chk("d1_done", 32'(done1), 32'd1);
      chk("d1_sample", 32'(sample1), 32'(ins1));
      @(posedge clk); #1;
      chk("d1_idle", 32'(busy1), 32'd0);
    end

`ifdef MUX_SCAN_MASK_EN
    // Sparse mask, all inputs high.
    ins = 4'hF;
    mask = 4'b1010;
    do_start();
    mask = 4'($urandom);
    observe_scan("mask1010", 4'hF, 4'b1010, -1);
    check_idle("mask1010", 4'b1010);

    // Empty mask: done the cycle after the start edge with a zero word.
    mask = 4'b0000;
    do_start();
    observe_scan("mask0", ins, 4'b0000, -1);
    check_idle("mask0", 4'b0000);
`endif

    // Random scans, optional random mask, random ignored start pokes.
    for (int r = 0; r < 8; r++) begin
      ins = 4'($urandom);
      pat = ins;
`ifdef MUX_SCAN_MASK_EN
      msk = 4'($urandom);
`else
      msk = 4'hF;
`endif
      mask = msk;
      k = $countones(msk);
      do_start();
`ifdef MUX_SCAN_MASK_EN
      mask = 4'($urandom);
`endif
      observe_scan("rand", pat, msk, (k > 0) ? $urandom_range(0, k * D - 1) : -1);
      check_idle("rand", pat & msk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_seq.md
# mux_scan_seq

Channel-scan sequencer that sits directly upstream of the team's 4:1 single-bit multiplexer. On a start request it steps the 2-bit select through channels 0→3, holds each select for a programmable dwell time, and samples the returned mux output. It then publishes all four samples as one 4-bit word with a single-cycle done pulse. An optional continuous mode re-arms the scan automatically.

## Interface
Parameters:
- DWELL, default 2: cycles each select value is held before its sample is taken; legal range 1..255.
- CNT_W, default 8: dwell counter width; must satisfy 2^CNT_W > DWELL.

Ports:
- clk, input, 1: single clock; all state on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a scan; sampled only in IDLE.
- cont, input, 1: continuous mode; sampled in DONE.
- mux_out, input, 1: output of the downstream 4:1 mux (combinational return path).
- sel, output, 2: select driven to the mux.
- busy, output, 1: high in SETTLE and DONE.
- done, output, 1: one-cycle pulse; sample is valid while it is high.
- sample, output, 4: bit n holds the value captured from channel n.
- ch_mask, input, 4: present only with MUX_SCAN_MASK_EN.

## Operation
- States: IDLE, SETTLE, DONE.
- IDLE: sel=0, busy=0, done=0, sample holds its last value.
  - start=1 → SETTLE, sel=first enabled channel (0 without mask), dwell count=0.
- SETTLE: count increments each cycle.
  - At count==DWELL-1: capture mux_out into shadow[sel] and clear count.
  - If sel is the last enabled channel → DONE. The full word loads into sample on this same edge; the final bit comes directly from mux_out.
  - Otherwise sel advances to the next enabled channel.
- DONE: lasts exactly one cycle with done=1.
  - cont=1 → SETTLE with sel=first channel.
  - cont=0 → IDLE with sel=0.
- start is ignored while busy; it is not queued.
- sel changes only on clock edges and is glitch-free (registered).

## Timing
- Reset values: sel=0, busy=0, done=0, sample=0, shadow=0, state=IDLE.
- Latency: start is sampled at edge E0. sel=0 is held for cycles E0..E0+DWELL; channel n is sampled at edge E0+(n+1)·DWELL. done is high for the cycle following edge E0+4·DWELL.
- Start to done, full scan: 4·DWELL cycles.
- Continuous mode: the next scan's sel=0 appears in the cycle after done. The period is 4·DWELL+1 cycles.
- DWELL=1: each channel is sampled one edge after its select is applied; the mux path must meet single-cycle timing.
- Reset asserted mid-scan: immediate return to reset values. The partial shadow is discarded and no done pulse is issued.
- start and cont both high in DONE: cont governs; start is ignored.

## Configuration
- MUX_SCAN_MASK_EN defined:
  - ch_mask port exists and is latched at start (or at the DONE→SETTLE re-arm).
  - Disabled channels are skipped with zero dwell, and their sample bits read 0.
  - ch_mask=0: SETTLE is bypassed; done pulses the cycle after the start edge with sample=0.
  - Scan time is popcount(mask)·DWELL.
- Not defined: no ch_mask port, and all four channels are always scanned.

## Structure
- Shared package mux_scan_pkg contains:
  - the state enum (IDLE, SETTLE, DONE)
  - NUM_CH=4 and SEL_W=2
  - a next-enabled-channel function used under the mask option
- One natural sub-module, mux_scan_dwell_cnt:
  - Parameters: DWELL and CNT_W.
  - Inputs: clear and enable.
  - Output: a terminal pulse at count DWELL-1.
- The top level owns the FSM, the sel register, the shadow register and the sample register.

## Test plan
- Reset, then a single scan with DWELL=2, a model mux and inputs i_0..i_3 = 1,0,1,1:
  - sel steps 0,1,2,3 every 2 cycles.
  - done pulses 8 cycles after start with sample=4'b1101.
- start pulsed while busy: ignored. Exactly one done; sample is unchanged by the second start.
- cont=1 held for three scans with inputs changing between scans:
  - done recurs every 9 cycles.
  - Each sample matches the inputs present during that scan.
- rst_n dropped at cycle 5 of a scan:
  - Outputs return to 0 asynchronously and no done occurs.
  - After release, a new start completes normally.
- DWELL=1, inputs 0,1,1,0: done 4 cycles after start, sample=4'b0110.
- With MUX_SCAN_MASK_EN:
  - ch_mask=4'b1010, inputs all 1: sel visits 1 then 3; done after 2·DWELL cycles; sample=4'b1010.
  - ch_mask=0: done the cycle after start, sample=0.
